register_window_shift: RTL and testbench
========================================

Name: register_window_shift

Overview:
- Parametrised successor to the single-stage enabled data register.
- Holds a chain of DEPTH registered stages, each WIDTH bits wide, that shift on enable. Forms the sliding-window line of the convolution datapath.
- Tracks fill level and flags complete windows with a registered valid pulse, decimated by a programmable stride.
- Sits between the feature-map fetch stage and the multiply-accumulate array.

Parameters:
- WIDTH, 32, bit width of one data word/stage.
- DEPTH, 5, number of stages (kernel size); legal range 2..16.
- STRIDE, 1, valid-window decimation: one valid per STRIDE full-window shifts; legal range 1..DEPTH.
- CNT_W, 5, width of COUNT; must satisfy 2^CNT_W > DEPTH.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-low reset.
- EN  in  1  shift enable: accept Din this cycle.
- CLR  in  1  synchronous clear of stages, count, stride phase.
- Din  in  WIDTH  newest data word.
- Dout  out  WIDTH*DEPTH  all stages flattened; Dout[WIDTH-1:0] = stage 0 (newest), top slice = stage DEPTH-1 (oldest).
- Dtail  out  WIDTH  copy of stage DEPTH-1 (oldest word).
- COUNT  out  CNT_W  number of valid words held, saturating at DEPTH.
- FULL  out  1  COUNT == DEPTH (combinational from COUNT).
- VALID  out  1  registered one-cycle pulse: window complete and on-stride.

Behaviour:
- Reset (RST low, asynchronous, independent of CLK):
  - all stages = 0, COUNT = 0, stride phase = 0, VALID = 0.
  - Consequently Dout = 0, Dtail = 0, FULL = 0.
  - Release is synchronous-safe: the first active edge after RST rises behaves as normal operation.
- Priority per rising edge: CLR > EN > hold.
- CLR = 1:
  - stages, COUNT and stride phase go to 0; VALID = 0 next cycle.
  - EN ignored that cycle.
- EN = 1, CLR = 0 (shift):
  - stage0 <= Din; stage[i] <= stage[i-1] for i = 1..DEPTH-1; old stage DEPTH-1 is discarded.
  - COUNT <= min(COUNT+1, DEPTH).
- EN = 0, CLR = 0: all state held; VALID <= 0.
- Latency: Din appears on stage 0 one cycle after the EN edge, and on Dtail DEPTH cycles (DEPTH enabled shifts) later.
- Stride / VALID logic, on each shift with CLR = 0:
  - Let cnt_next = post-shift COUNT.
  - If cnt_next == DEPTH:
    - VALID <= (phase == 0).
    - phase <= (phase == STRIDE-1) ? 0 : phase+1.
  - Otherwise VALID <= 0 and phase unchanged.
  - The first full window is therefore always flagged.
  - With STRIDE = 1, VALID accompanies every shift once FULL.
- VALID is high only for the single cycle after a qualifying shift. Back-to-back qualifying shifts give a continuous high for STRIDE = 1.
- While VALID = 1, Dout holds the exact window that produced it.
- COUNT saturates at DEPTH; no wrap-around.
- Phase counter wraps modulo STRIDE and never exceeds STRIDE-1.
- CLR mid-window: partial window discarded; refill requires DEPTH new shifts before the next VALID.
- Reset mid-operation: same effect as CLR, but immediate and asynchronous. VALID drops without waiting for an edge.
- EN held high continuously is legal; one word is accepted per cycle with no back-pressure.
- No X-propagation from Din into COUNT, phase or VALID; these depend only on EN, CLR and RST.

Test Plan:
- Reset: RST low mid-stream with WIDTH=8, DEPTH=3, STRIDE=2 -> Dout = 0, Dtail = 0, COUNT = 0, FULL = 0, VALID = 0 immediately, before any CLK edge.
- Fill: shift 0x01, 0x02, 0x03 on consecutive cycles.
  - COUNT goes 1, 2, 3; FULL = 1 after the third edge.
  - VALID = 1 for one cycle with Dout = {0x01, 0x02, 0x03} (oldest..newest) and Dtail = 0x01.
- Stride: continue with 0x04 then 0x05.
  - After 0x04: VALID = 0.
  - After 0x05: VALID = 1 with Dout = {0x03, 0x04, 0x05}; COUNT stays 3.
- Hold/gap: EN = 0 for 4 cycles between shifts -> Dout, COUNT and phase are unchanged and VALID = 0 throughout; stride sequence resumes correctly.
- CLR vs EN: assert CLR = 1 and EN = 1 together with Din = 0xAA.
  - Stages = 0, COUNT = 0, no VALID.
  - Three more shifts are needed before VALID reasserts.
- STRIDE = 1, DEPTH = 5: stream 10 words with EN high continuously -> VALID high on cycles 5 through 10 (6 pulses). Each window equals the last 5 inputs.

Source files
------------

// File: rtl/register_window_shift_if.sv
// Bundle of the shift-window control, data and status signals.
// The upstream fetch stage drives through master; the window register sits on slave.
interface register_window_shift_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 5,
    parameter int CNT_W = 5
);
    logic                     EN;
    logic                     CLR;
    logic [WIDTH-1:0]         Din;
    logic [WIDTH*DEPTH-1:0]   Dout;
    logic [WIDTH-1:0]         Dtail;
    logic [CNT_W-1:0]         COUNT;
    logic                     FULL;
    logic                     VALID;

    modport master (
        output EN, CLR, Din,
        input  Dout, Dtail, COUNT, FULL, VALID
    );

    modport slave (
        input  EN, CLR, Din,
        output Dout, Dtail, COUNT, FULL, VALID
    );
endinterface

// File: rtl/register_window_shift.sv
// Sliding-window shift line for the convolution datapath: DEPTH stages of
// WIDTH bits shift on enable, fill level is tracked with saturation, and a
// registered VALID pulse marks each full window that lands on the stride.
module register_window_shift #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 5,
    parameter int STRIDE = 1,
    parameter int CNT_W  = 5
) (
    input  logic                   CLK,
    input  logic                   RST,
    register_window_shift_if.slave bus
);
    localparam int                 PH_W    = (STRIDE > 1) ? $clog2(STRIDE) : 1;
    localparam logic [CNT_W-1:0]   DEPTH_C = CNT_W'(DEPTH);
    localparam logic [PH_W-1:0]    PH_LAST = PH_W'(STRIDE - 1);

    logic [WIDTH-1:0] stage [DEPTH];
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] cnt_next;
    logic [PH_W-1:0]  phase;
    logic             valid;

    // Post-shift fill level, saturating at DEPTH.
    always_comb begin
        cnt_next = (count == DEPTH_C) ? count : count + 1'b1;
    end

    // Data stages: newest word enters stage 0, oldest falls off stage DEPTH-1.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else if (bus.CLR) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else if (bus.EN) begin
            stage[0] <= bus.Din;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    // Fill count, stride phase and window-valid pulse; independent of Din.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            count <= '0;
            phase <= '0;
            valid <= 1'b0;
        end else if (bus.CLR) begin
            count <= '0;
            phase <= '0;
            valid <= 1'b0;
        end else if (bus.EN) begin
            count <= cnt_next;
            if (cnt_next == DEPTH_C) begin
                // First full window always fires because phase starts at 0.
                valid <= (phase == '0);
                phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;
            end else begin
                valid <= 1'b0;
            end
        end else begin
            valid <= 1'b0;
        end
    end

    genvar g;
    generate
        for (g = 0; g < DEPTH; g++) begin : g_flat
            assign bus.Dout[g*WIDTH +: WIDTH] = stage[g];
        end
    endgenerate

    assign bus.Dtail = stage[DEPTH-1];
    assign bus.COUNT = count;
    assign bus.FULL  = (count == DEPTH_C);
    assign bus.VALID = valid;
endmodule

// File: tb/tb_register_window_shift.sv
// Directed bench: DEPTH=3/STRIDE=2 instance for fill, stride, hold, clear and
// async reset; DEPTH=5/STRIDE=1 instance for continuous streaming.
module tb_register_window_shift;
    logic CLK;
    logic RST;
    int   checks;
    int   errors;

    register_window_shift_if #(.WIDTH(8), .DEPTH(3), .CNT_W(5)) bus_a ();
    register_window_shift_if #(.WIDTH(8), .DEPTH(5), .CNT_W(5)) bus_b ();

    register_window_shift #(.WIDTH(8), .DEPTH(3), .STRIDE(2), .CNT_W(5)) dut_a (
        .CLK (CLK),
        .RST (RST),
        .bus (bus_a)
    );

    register_window_shift #(.WIDTH(8), .DEPTH(5), .STRIDE(1), .CNT_W(5)) dut_b (
        .CLK (CLK),
        .RST (RST),
        .bus (bus_b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic [23:0] dout, input logic [4:0] cnt,
                         input logic full, input logic vld);
        chk({tag, ".dout"},  64'(bus_a.Dout),  64'(dout));
        chk({tag, ".dtail"}, 64'(bus_a.Dtail), 64'(dout[23:16]));
        chk({tag, ".count"}, 64'(bus_a.COUNT), 64'(cnt));
        chk({tag, ".full"},  64'(bus_a.FULL),  64'(full));
        chk({tag, ".valid"}, 64'(bus_a.VALID), 64'(vld));
    endtask

    initial begin
        logic [39:0] win;
        checks = 0;
        errors = 0;
        RST = 1'b0;
        bus_a.EN = 1'b0; bus_a.CLR = 1'b0; bus_a.Din = '0;
        bus_b.EN = 1'b0; bus_b.CLR = 1'b0; bus_b.Din = '0;
        step();
        step();
        chk_a("reset", 24'h000000, 5'd0, 1'b0, 1'b0);
        RST = 1'b1;

        // Fill
        bus_a.EN = 1'b1;
        bus_a.Din = 8'h01; step(); chk_a("fill1", 24'h000001, 5'd1, 1'b0, 1'b0);
        bus_a.Din = 8'h02; step(); chk_a("fill2", 24'h000102, 5'd2, 1'b0, 1'b0);
        bus_a.Din = 8'h03; step(); chk_a("fill3", 24'h010203, 5'd3, 1'b1, 1'b1);

        // Stride 2
        bus_a.Din = 8'h04; step(); chk_a("str4", 24'h020304, 5'd3, 1'b1, 1'b0);
        bus_a.Din = 8'h05; step(); chk_a("str5", 24'h030405, 5'd3, 1'b1, 1'b1);

        // Hold gap, Din toggling must not matter
        bus_a.EN = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus_a.Din = 8'hE0 + 8'(i);
            step();
            chk_a("hold", 24'h030405, 5'd3, 1'b1, 1'b0);
        end
        bus_a.EN = 1'b1;
        bus_a.Din = 8'h06; step(); chk_a("resume6", 24'h040506, 5'd3, 1'b1, 1'b0);
        bus_a.Din = 8'h07; step(); chk_a("resume7", 24'h050607, 5'd3, 1'b1, 1'b1);

        // CLR beats EN
        bus_a.CLR = 1'b1; bus_a.Din = 8'hAA; step();
        chk_a("clr", 24'h000000, 5'd0, 1'b0, 1'b0);
        bus_a.CLR = 1'b0;
        bus_a.Din = 8'h11; step(); chk_a("refill1", 24'h000011, 5'd1, 1'b0, 1'b0);
        bus_a.Din = 8'h12; step(); chk_a("refill2", 24'h001112, 5'd2, 1'b0, 1'b0);
        bus_a.Din = 8'h13; step(); chk_a("refill3", 24'h111213, 5'd3, 1'b1, 1'b1);

        // Async reset mid-stream, between edges, while VALID is high
        #2;
        RST = 1'b0;
        #1;
        chk_a("async_rst", 24'h000000, 5'd0, 1'b0, 1'b0);
        bus_a.EN = 1'b0;
        RST = 1'b1;
        step();
        chk_a("post_rst", 24'h000000, 5'd0, 1'b0, 1'b0);

        // STRIDE=1, DEPTH=5 continuous stream
        bus_b.EN = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            bus_b.Din = 8'(k);
            step();
            for (int j = 0; j < 5; j++) win[j*8 +: 8] = (k - j > 0) ? 8'(k - j) : 8'h00;
            chk("b.count", 64'(bus_b.COUNT), (k < 5) ? 64'(k) : 64'd5);
            chk("b.valid", 64'(bus_b.VALID), (k >= 5) ? 64'd1 : 64'd0);
            chk("b.dout",  64'(bus_b.Dout),  64'(win));
            chk("b.dtail", 64'(bus_b.Dtail), 64'(win[39:32]));
        end
        bus_b.EN = 1'b0;
        step();
        chk("b.valid_drop", 64'(bus_b.VALID), 64'd0);
        chk("b.full_hold",  64'(bus_b.FULL),  64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
